if_fetch_stage: RTL

Instruction-fetch stage directly upstream of the PC/branch control block. Owns the architectural PC register and issues word fetches to instruction memory over a req/gnt/rvalid handshake. Buffers returned instructions with their PC in a small FIFO for decode, and accepts redirects from the branch/jump control logic, flushing stale fetches.

---
 rtl/if_fetch_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage. Owns the architectural fetch PC, issues one word
// fetch at a time to instruction memory, and buffers returned instructions
// (tagged with their PC) in a small FIFO for decode. Redirects from the
// branch/jump control logic flush the FIFO and retarget the PC; a fetch that
// is already in flight at redirect time has its data dropped (DRAIN).
//
// Handshakes:
//   imem: a request transfers on a cycle with imem_req && imem_gnt; imem_addr
//         holds pc_q until then. Exactly one response (imem_rvalid) follows
//         at least one cycle later; at most one request is ever outstanding.
//   decode: the head entry transfers on a cycle with if_valid && if_ready;
//         if_pc/if_instr are stable while if_valid is high and not popped.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        fence_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        fetch_idle,
  output logic [31:0] pc,
  output logic [1:0]  dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       tag_pc_q, tag_pc_d;

  logic [31:0]       pc_mem_q    [FIFO_DEPTH];
  logic [31:0]       pc_mem_d    [FIFO_DEPTH];
  logic [31:0]       instr_mem_q [FIFO_DEPTH];
  logic [31:0]       instr_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              outstanding;
  logic [CNT_W-1:0]  occupancy;
  logic [31:0]       target_pc;
  logic              push;
  logic              pop;
  logic              flush;

  // A request is in flight in WAIT (data kept) and DRAIN (data dropped).
  assign outstanding = (state_q == S_WAIT) || (state_q == S_DRAIN);
  // Slots already claimed: buffered entries plus the one in flight.
  assign occupancy   = count_q + CNT_W'(outstanding);
  assign target_pc   = redirect_pc & 32'hFFFF_FFFC;

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_valid    = (count_q != '0);
  assign if_pc       = if_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
  assign if_instr    = if_valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
  assign fetch_idle  = !outstanding && (count_q == '0);
  assign dbg_state   = state_q;

  // Fetch FSM: next state, PC update, request and FIFO push/flush decisions.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tag_pc_d = tag_pc_q;
    imem_req = 1'b0;
    push     = 1'b0;
    flush    = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = target_pc;
      end
      S_REQ: begin
        imem_req = !fence_i && (occupancy < DEPTH_C);
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = target_pc;
          // A request accepted on this very edge still owes a response.
          state_d = (imem_req && imem_gnt) ? S_DRAIN : S_REQ;
        end else if (imem_req && imem_gnt) begin
          tag_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pc_d    = target_pc;
          // Response arriving with the redirect is simply dropped here.
          state_d = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid) begin
          push    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          pc_d  = target_pc;
        end
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    // A flush empties the FIFO, so a same-cycle pop must not also count.
    pop = if_valid && if_ready && !flush;
  end

  // Instruction FIFO: flush, push/pop pointers and occupancy count.
  always_comb begin
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = tag_pc_q;
        instr_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end
  end

  // State, PC and FIFO registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      tag_pc_q <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]    <= 32'h0;
        instr_mem_q[i] <= 32'h0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      tag_pc_q    <= tag_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
    end
  end

endmodule
